// File: rtl/stage_3.sv
// Pairs consecutive CORDIC result beats into a widened signed sum with both squared side values.
// Registered outputs one cycle after the second beat; no backpressure, so any unpaired first beat is dropped on drain.
module stage_3 #(
    parameter int CORDIC_DATA_WIDTH = 22,
    parameter int FLOAT_DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [CORDIC_DATA_WIDTH-1:0] result,
    input  logic [FLOAT_DATA_WIDTH-1:0]  squared_pipeline,
    input  logic                         valid,
    input  logic                         pipeline_cleared,
    output logic [CORDIC_DATA_WIDTH:0]   sum,
    output logic [FLOAT_DATA_WIDTH-1:0]  one_sq,
    output logic [FLOAT_DATA_WIDTH-1:0]  two_sq,
    output logic                         sum_valid,
    output logic                         orphan,
    output logic                         done,
    output logic [COUNT_WIDTH-1:0]       pair_count
);

    localparam logic [0:0] WAIT_FIRST  = 1'b0;
    localparam logic [0:0] WAIT_SECOND = 1'b1;

    logic [0:0]                   r_state;
    logic [CORDIC_DATA_WIDTH-1:0] r_held_res;
    logic [FLOAT_DATA_WIDTH-1:0]  r_held_sq;
    logic [CORDIC_DATA_WIDTH:0]   r_sum;
    logic [FLOAT_DATA_WIDTH-1:0]  r_one_sq;
    logic [FLOAT_DATA_WIDTH-1:0]  r_two_sq;
    logic                         r_sum_valid;
    logic                         r_orphan;
    logic                         r_done;
    logic [COUNT_WIDTH-1:0]       r_pair_count;

    logic                         w_take_first;
    logic                         w_pair;
    logic                         w_drop;
    logic                         w_idle_done;
    logic [CORDIC_DATA_WIDTH:0]   w_sum;

    assign w_take_first = clk_en && (r_state == WAIT_FIRST) && valid;
    assign w_idle_done  = clk_en && (r_state == WAIT_FIRST) && !valid && pipeline_cleared;
    assign w_pair       = clk_en && (r_state == WAIT_SECOND) && valid;
    assign w_drop       = clk_en && (r_state == WAIT_SECOND) && !valid && pipeline_cleared;

    // One extra bit after sign extension makes the sum overflow-free.
    assign w_sum = {r_held_res[CORDIC_DATA_WIDTH-1], r_held_res}
                 + {result[CORDIC_DATA_WIDTH-1], result};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_FIRST;
        end else if (w_take_first) begin
            r_state <= WAIT_SECOND;
        end else if (w_pair || w_drop) begin
            r_state <= WAIT_FIRST;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_held_res <= '0;
            r_held_sq  <= '0;
        end else if (w_take_first) begin
            r_held_res <= result;
            r_held_sq  <= squared_pipeline;
        end else if (w_drop) begin
            r_held_res <= '0;
            r_held_sq  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum        <= '0;
            r_one_sq     <= '0;
            r_two_sq     <= '0;
            r_pair_count <= '0;
        end else if (w_pair) begin
            r_sum        <= w_sum;
            r_one_sq     <= r_held_sq;
            r_two_sq     <= squared_pipeline;
            r_pair_count <= r_pair_count + COUNT_WIDTH'(1);
        end
    end

    // Status pulses clear on every edge, independent of clk_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_valid <= 1'b0;
            r_orphan    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sum_valid <= w_pair;
            r_orphan    <= w_drop;
            r_done      <= w_idle_done || (w_pair && pipeline_cleared);
        end
    end

    assign sum        = r_sum;
    assign one_sq     = r_one_sq;
    assign two_sq     = r_two_sq;
    assign sum_valid  = r_sum_valid;
    assign orphan     = r_orphan;
    assign done       = r_done;
    assign pair_count = r_pair_count;

endmodule
